// File: rtl/alu_pkg.sv
// Shared opcode encoding and sequencer state type for the ALU command path.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [3:0] OP_MAX = 4'h6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp,
    StRespHi
  } seq_state_e;

  function automatic logic op_is_legal(logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Command sequencer for the external ALU: issues one op, waits out the ALU
// latency and returns the result as one beat (two beats, lo then hi, for MUL).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [3:0]   cmd_op_i,
  input  logic [W-1:0] cmd_a_i,
  input  logic [W-1:0] cmd_b_i,
  input  logic         cmd_chain_i,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic [3:0]   alu_ins_o,
  input  logic [W-1:0] alu_out_i,
  input  logic [W-1:0] alu_hi_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic         res_last_o,
  output logic         res_err_o,
  output logic         busy_o
);

  // The ALU inputs are themselves registered here, so the ALU result becomes
  // visible ALU_LAT edges after issue and is sampled on the edge after that.
  localparam logic [2:0] WaitLoad = 3'(ALU_LAT);

  seq_state_e   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         is_mul_q, is_mul_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] last_res_q, last_res_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_ins_q, alu_ins_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         res_valid_q, res_valid_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_last_q, res_last_d;
  logic         res_err_q, res_err_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_mul_d    = is_mul_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    last_res_d  = last_res_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ins_d   = alu_ins_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          if (cmd_op_i == OP_NOP) begin
            state_d = StIdle;
          end else if (op_is_legal(cmd_op_i)) begin
            alu_a_d   = cmd_chain_i ? last_res_q : cmd_a_i;
            alu_b_d   = cmd_b_i;
            alu_ins_d = cmd_op_i;
            is_mul_d  = (cmd_op_i == OP_MUL);
            cnt_d     = WaitLoad;
            state_d   = StExec;
          end else begin
            // Illegal opcode: never reaches the ALU, answered with an error beat.
            is_mul_d    = 1'b0;
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_last_d  = 1'b1;
            res_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StExec: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          lo_d        = alu_out_i;
          hi_d        = alu_hi_i;
          res_data_d  = alu_out_i;
          res_last_d  = !is_mul_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          alu_ins_d   = OP_NOP;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (res_ready_i) begin
          if (!res_err_q) begin
            last_res_d = lo_q;
          end
          if (is_mul_q) begin
            res_data_d = hi_q;
            res_last_d = 1'b1;
            state_d    = StRespHi;
          end else begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_err_d   = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StRespHi: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_mul_q    <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      last_res_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ins_q   <= OP_NOP;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_mul_q    <= is_mul_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      last_res_q  <= last_res_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ins_q   <= alu_ins_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_ins_o   = alu_ins_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_last_o  = res_last_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a one-cycle registered ALU model attached.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'h0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_chain = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_ins;
  logic [15:0] alu_out = '0;
  logic [15:0] alu_hi = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        res_last, res_err, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ALU model: registered result, one clock after its inputs change.
  logic [31:0] prod;
  assign prod = alu_a * alu_b;
  always_ff @(posedge clk) begin
    alu_hi <= '0;
    case (alu_ins)
      OP_ADD: alu_out <= alu_a + alu_b;
      OP_SUB: alu_out <= alu_a - alu_b;
      OP_MUL: begin alu_out <= prod[15:0]; alu_hi <= prod[31:16]; end
      OP_CMP: alu_out <= {15'd0, alu_a < alu_b};
      OP_AND: alu_out <= alu_a & alu_b;
      OP_OR:  alu_out <= alu_a | alu_b;
      OP_XOR: alu_out <= alu_a ^ alu_b;
      default: alu_out <= '0;
    endcase
  end

  alu_seq #(.W(16), .ALU_LAT(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_chain_i (cmd_chain),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_ins_o   (alu_ins),
    .alu_out_i   (alu_out),
    .alu_hi_i    (alu_hi),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_last_o  (res_last),
    .res_err_o   (res_err),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns just after its accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic chain);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    tick();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!res_valid && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    vectors++;
    if ({res_valid, res_last, res_err, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {res_valid, res_last, res_err, busy});
    end
    vectors++;
    if ({alu_ins, alu_a, alu_b, res_data} !== {4'hF, 48'h0}) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h/%h want f/0/0/0", alu_ins, alu_a, alu_b, res_data);
    end
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    issue(OP_ADD, 16'h0003, 16'h0004, 1'b0);
    vectors++;
    if ({busy, cmd_ready, res_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL add_accept: busy/ready/valid got %b want 100", {busy, cmd_ready, res_valid});
    end
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++; $display("FAIL add_early: res_valid got %b want 0", res_valid);
    end
    tick();
    vectors++;
    if ({res_valid, res_last, res_err, res_data} !== {3'b110, 16'h0007}) begin
      miscompares++;
      $display("FAIL add_beat: v/l/e/data got %b%b%b/%h want 110/0007",
               res_valid, res_last, res_err, res_data);
    end
    tick();
    vectors++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL add_done: valid/ready got %b want 01", {res_valid, cmd_ready});
    end
  endtask

  task automatic test_mul();
    res_ready = 1'b1;
    issue(OP_MUL, 16'h1234, 16'h0100, 1'b0);
    tick();
    tick();
    vectors++;
    if ({res_valid, res_last, res_data} !== {2'b10, 16'h3400}) begin
      miscompares++;
      $display("FAIL mul_lo: v/l/data got %b%b/%h want 10/3400", res_valid, res_last, res_data);
    end
    tick();
    vectors++;
    if ({res_valid, res_last, res_data} !== {2'b11, 16'h0012}) begin
      miscompares++;
      $display("FAIL mul_hi: v/l/data got %b%b/%h want 11/0012", res_valid, res_last, res_data);
    end
    tick();
    vectors++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL mul_done: valid/ready got %b want 01", {res_valid, cmd_ready});
    end
  endtask

  task automatic test_chain();
    res_ready = 1'b1;
    issue(OP_ADD, 16'h0005, 16'h0006, 1'b0);
    wait_valid(10);
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 16'h000B) begin
      miscompares++;
      $display("FAIL chain_first: valid/data got %b/%h want 1/000b", res_valid, res_data);
    end
    tick();
    issue(OP_SUB, 16'hFFFF, 16'h0001, 1'b1);
    vectors++;
    if (alu_a !== 16'h000B || alu_ins !== OP_SUB) begin
      miscompares++;
      $display("FAIL chain_issue: alu_a/ins got %h/%h want 000b/1", alu_a, alu_ins);
    end
    wait_valid(10);
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 16'h000A) begin
      miscompares++;
      $display("FAIL chain_second: valid/data got %b/%h want 1/000a", res_valid, res_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    issue(OP_MUL, 16'hABCD, 16'h0010, 1'b0);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({res_valid, res_last, cmd_ready, res_data} !== {3'b100, 16'hBCD0}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: v/l/rdy/data got %b%b%b/%h want 100/bcd0",
                 i, res_valid, res_last, cmd_ready, res_data);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    vectors++;
    if ({res_valid, res_last, res_data} !== {2'b11, 16'h000A}) begin
      miscompares++;
      $display("FAIL bp_hi: v/l/data got %b%b/%h want 11/000a", res_valid, res_last, res_data);
    end
    tick();
    vectors++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_done: valid/ready got %b want 01", {res_valid, cmd_ready});
    end
  endtask

  task automatic test_illegal();
    res_ready = 1'b1;
    issue(4'h9, 16'h0001, 16'h0002, 1'b0);
    vectors++;
    if ({res_valid, res_err, res_last, res_data, alu_ins} !== {3'b111, 16'h0, 4'hF}) begin
      miscompares++;
      $display("FAIL illegal_beat: v/e/l/data/ins got %b%b%b/%h/%h want 111/0000/f",
               res_valid, res_err, res_last, res_data, alu_ins);
    end
    tick();
    vectors++;
    if ({res_valid, res_err, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL illegal_done: v/e/rdy got %b want 001", {res_valid, res_err, cmd_ready});
    end
    // last_res must still hold the lo beat of the previous MUL
    issue(OP_ADD, 16'h1234, 16'h0000, 1'b1);
    wait_valid(10);
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 16'hBCD0) begin
      miscompares++;
      $display("FAIL illegal_last_res: valid/data got %b/%h want 1/bcd0", res_valid, res_data);
    end
    tick();
  endtask

  task automatic test_nop();
    bit seen = 1'b0;
    res_ready = 1'b1;
    issue(OP_NOP, 16'h0007, 16'h0007, 1'b0);
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL nop_idle: ready/busy got %b want 10", {cmd_ready, busy});
    end
    for (int i = 0; i < 4; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL nop_no_beat: beat seen %b want 0", seen);
    end
  endtask

  task automatic test_rst_abort();
    bit seen = 1'b0;
    res_ready = 1'b1;
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({cmd_ready, res_valid, busy, alu_ins} !== {3'b100, 4'hF}) begin
      miscompares++;
      $display("FAIL rst_exec: rdy/v/busy/ins got %b%b%b/%h want 100/f",
               cmd_ready, res_valid, busy, alu_ins);
    end
    for (int i = 0; i < 4; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL rst_exec_stray: beat seen %b want 0", seen);
    end
    issue(OP_MUL, 16'h1234, 16'h0100, 1'b0);
    tick();
    tick();
    tick();
    res_ready = 1'b0;
    vectors++;
    if ({res_valid, res_last, res_data} !== {2'b11, 16'h0012}) begin
      miscompares++;
      $display("FAIL rst_hi_reach: v/l/data got %b%b/%h want 11/0012", res_valid, res_last, res_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({cmd_ready, res_valid, res_last, res_data} !== {3'b100, 16'h0}) begin
      miscompares++;
      $display("FAIL rst_hi: rdy/v/l/data got %b%b%b/%h want 100/0000",
               cmd_ready, res_valid, res_last, res_data);
    end
    res_ready = 1'b1;
    // last_res was cleared by reset, so a chained add sees A=0
    issue(OP_ADD, 16'hFFFF, 16'h0003, 1'b1);
    wait_valid(10);
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 16'h0003) begin
      miscompares++;
      $display("FAIL rst_after_add: valid/data got %b/%h want 1/0003", res_valid, res_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_chain();
    test_backpressure();
    test_illegal();
    test_nop();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
